bnn_qkv_engine: RTL and testbench
=================================

BNN_QKV_ENGINE -- requirements
Module: bnn_qkv_engine

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning binarised input token width in bits.
REQ-002 SHALL have parameter OUT_W, default 16, meaning output bits per projection (Q, K and V each).
REQ-003 SHALL have parameter NUM_BLK, default 8, meaning number of weight blocks selectable per token.
REQ-004 SHALL have parameter SEQ_LEN, default 30, meaning tokens per sequence.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, meaning the input token is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a token this cycle.
REQ-009 SHALL have port in_data, input, IN_W, meaning the token (bit 1 = +1, bit 0 = -1).
REQ-010 SHALL have port block_sel, input, $clog2(NUM_BLK), meaning the weight block for this token, sampled with in_data.
REQ-011 SHALL have port w_en, output, 1, meaning weight memory read enable.
REQ-012 SHALL have port w_addr, output, $clog2(NUM_BLK), meaning weight memory address.
REQ-013 SHALL have port w_data, input, 3*OUT_W*IN_W, meaning weight row returned 1 cycle after w_en; held while w_en=0. Q occupies the low OUT_W*IN_W bits, then K, then V. Output bit i uses slice [i*IN_W +: IN_W].
REQ-014 SHALL have ports q_out, k_out and v_out, each output, OUT_W, meaning the binarised projections.
REQ-015 SHALL have port out_valid, output, 1, meaning q/k/v_out are valid.
REQ-016 SHALL have port out_ready, input, 1, meaning the consumer accepts the output.
REQ-017 SHALL have port out_last, output, 1, meaning the current output is token SEQ_LEN-1 of the sequence.
REQ-018 SHALL have port done, output, 1, meaning the sticky flag that a sequence has completed.
REQ-019 SHALL have port clear, input, 1, meaning a synchronous clear of done and the token counter.

Function
REQ-020 SHALL accept a token when in_valid && in_ready; on acceptance it SHALL drive w_en=1 and w_addr=block_sel, and capture in_data into stage 1.
REQ-021 SHALL compute in stage 2, for each output bit i: pop = popcount(~(W[i] ^ token)), with width $clog2(IN_W+1) bits, unsigned.
REQ-022 SHALL set the output bit to 1 iff 2*pop >= IN_W, evaluated without signed underflow; for IN_W=16 this means pop >= 8.
REQ-023 SHALL register the outputs; latency from input handshake to out_valid SHALL be exactly 2 cycles when not stalled.
REQ-024 SHALL sustain a throughput of 1 token/cycle while out_ready=1.
REQ-025 SHALL, when out_valid && !out_ready, hold q/k/v_out, out_valid and out_last stable.
REQ-026 SHALL, when out_valid && !out_ready, hold stage 1, drive w_en=0, and set in_ready=0 once stage 1 is occupied.
REQ-027 SHALL drive in_ready = !s1_valid || !out_valid || out_ready, with no combinational path from in_valid to in_ready.
REQ-028 SHALL keep a token counter of width $clog2(SEQ_LEN) that increments on each output handshake.
REQ-029 SHALL assert out_last when the counter equals SEQ_LEN-1; on that handshake the counter SHALL wrap to 0 and done SHALL be set 1 cycle later.
REQ-030 SHALL keep done at 1 until clear or reset; further sequences SHALL continue to process normally.
REQ-031 SHALL, on clear, zero the counter and done next cycle. If clear coincides with a last handshake, clear SHALL win: done=0 and counter=0.
REQ-032 SHALL, if clear coincides with a non-last handshake, set counter=0; the in-flight pipeline data SHALL be unaffected.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force q/k/v_out=0, out_valid=0, out_last=0, done=0, w_en=0, w_addr=0, counter=0 and stage-1 valid=0.
REQ-034 SHALL drive in_ready=1 during and after reset.
REQ-035 SHALL discard any tokens in flight when reset asserts mid-sequence; the first output after release SHALL be token 0.

Configuration
REQ-036 SHALL, when QKV_POPCNT_OUT_EN is defined, add outputs q_pop, k_pop and v_pop, each OUT_W*$clog2(IN_W+1) bits, carrying the raw popcounts registered and stalled alongside q/k/v_out, with reset value 0.
REQ-037 SHALL, when QKV_POPCNT_OUT_EN is undefined, not have these ports and not have their registers.

Verification
REQ-038 SHALL cover: IN_W=16, all weights 0xFFFF, token 0x00FF (pop=8) -> all q/k/v bits = 1 two cycles after the handshake.
REQ-039 SHALL cover: weights 0xFFFF, token 0x007F (pop=7) -> all bits 0; token 0x0000 -> 0; token 0xFFFF -> 1.
REQ-040 SHALL cover: 30 back-to-back tokens with out_ready=1 -> 30 consecutive out_valid cycles, out_last only on the 30th, done=1 the next cycle and staying 1.
REQ-041 SHALL cover: out_ready=0 for 5 cycles mid-stream -> outputs stable, in_ready=0 after 1 more acceptance, no token lost or duplicated, and w_en=0 during the stall.
REQ-042 SHALL cover: block_sel alternating 0/7 with distinct ROM rows -> each output matches the reference model for its own block.
REQ-043 SHALL cover: rst_n pulsed low at token 12, then clear asserted together with the last handshake -> all outputs 0 asynchronously; counter restarts at 0; done stays 0.

Source files
------------

// File: rtl/bnn_qkv_engine.sv
// Binarised Q/K/V projection: XNOR-popcount of each token against one selected weight row, 2-cycle latency, valid/ready on both sides.
// Optional QKV_POPCNT_OUT_EN adds registered raw popcount outputs q_pop/k_pop/v_pop.
module bnn_qkv_engine #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int NUM_BLK = 8,
  parameter int SEQ_LEN = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  input  logic [$clog2(NUM_BLK)-1:0]    block_sel,
  output logic                          w_en,
  output logic [$clog2(NUM_BLK)-1:0]    w_addr,
  input  logic [3*OUT_W*IN_W-1:0]       w_data,
  output logic [OUT_W-1:0]              q_out,
  output logic [OUT_W-1:0]              k_out,
  output logic [OUT_W-1:0]              v_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          done,
  input  logic                          clear
`ifdef QKV_POPCNT_OUT_EN
  ,
  output logic [OUT_W*$clog2(IN_W+1)-1:0] q_pop,
  output logic [OUT_W*$clog2(IN_W+1)-1:0] k_pop,
  output logic [OUT_W*$clog2(IN_W+1)-1:0] v_pop
`endif
);

  localparam int PW   = $clog2(IN_W+1);
  localparam int CW   = $clog2(SEQ_LEN);
  localparam int WROW = OUT_W*IN_W;
  localparam logic [CW-1:0] LAST = CW'(SEQ_LEN-1);

  logic              s1_vld_q, s1_vld_d;
  logic [IN_W-1:0]   s1_dat_q, s1_dat_d;
  logic              out_vld_q, out_vld_d;
  logic [OUT_W-1:0]  q_q, q_d, k_q, k_d, v_q, v_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              accept, advance, out_hs;
  logic [PW-1:0]     q_pc [OUT_W];
  logic [PW-1:0]     k_pc [OUT_W];
  logic [PW-1:0]     v_pc [OUT_W];
  logic [OUT_W-1:0]  q_bit, k_bit, v_bit;

  function automatic logic [PW-1:0] popcnt(input logic [IN_W-1:0] x);
    logic [PW-1:0] c;
    c = '0;
    for (int j = 0; j < IN_W; j++) c = c + {{(PW-1){1'b0}}, x[j]};
    return c;
  endfunction

  // 2*pop >= IN_W, done one bit wider so nothing can wrap
  function automatic logic ge_half(input logic [PW-1:0] p);
    return {p, 1'b0} >= (PW+1)'(IN_W);
  endfunction

  // Stage 1 only drains when the output register is free or being consumed
  assign advance  = s1_vld_q && (!out_vld_q || out_ready);
  assign in_ready = !s1_vld_q || advance;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_vld_q && out_ready;

  // The weight read is issued in the acceptance cycle so the row lines up with stage 1
  assign w_en   = accept && rst_n;
  assign w_addr = w_en ? block_sel : '0;

  always_comb begin
    q_bit = '0;
    k_bit = '0;
    v_bit = '0;
    for (int i = 0; i < OUT_W; i++) begin
      q_pc[i]  = popcnt(~(w_data[i*IN_W +: IN_W] ^ s1_dat_q));
      k_pc[i]  = popcnt(~(w_data[WROW + i*IN_W +: IN_W] ^ s1_dat_q));
      v_pc[i]  = popcnt(~(w_data[2*WROW + i*IN_W +: IN_W] ^ s1_dat_q));
      q_bit[i] = ge_half(q_pc[i]);
      k_bit[i] = ge_half(k_pc[i]);
      v_bit[i] = ge_half(v_pc[i]);
    end
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_dat_d = in_data;
    end else if (advance) begin
      s1_vld_d = 1'b0;
    end

    out_vld_d = advance || (out_vld_q && !out_ready);
    q_d = q_q;
    k_d = k_q;
    v_d = v_q;
    if (advance) begin
      q_d = q_bit;
      k_d = k_bit;
      v_d = v_bit;
    end

    // clear takes priority over a coinciding last handshake
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (out_hs) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      out_vld_q <= 1'b0;
      q_q       <= '0;
      k_q       <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      out_vld_q <= out_vld_d;
      q_q       <= q_d;
      k_q       <= k_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign q_out     = q_q;
  assign k_out     = k_q;
  assign v_out     = v_q;
  assign out_valid = out_vld_q;
  assign out_last  = out_vld_q && (cnt_q == LAST);
  assign done      = done_q;

`ifdef QKV_POPCNT_OUT_EN
  logic [OUT_W*PW-1:0] q_pop_q, q_pop_d, k_pop_q, k_pop_d, v_pop_q, v_pop_d;

  always_comb begin
    q_pop_d = q_pop_q;
    k_pop_d = k_pop_q;
    v_pop_d = v_pop_q;
    if (advance) begin
      for (int i = 0; i < OUT_W; i++) begin
        q_pop_d[i*PW +: PW] = q_pc[i];
        k_pop_d[i*PW +: PW] = k_pc[i];
        v_pop_d[i*PW +: PW] = v_pc[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pop_q <= '0;
      k_pop_q <= '0;
      v_pop_q <= '0;
    end else begin
      q_pop_q <= q_pop_d;
      k_pop_q <= k_pop_d;
      v_pop_q <= v_pop_d;
    end
  end

  assign q_pop = q_pop_q;
  assign k_pop = k_pop_q;
  assign v_pop = v_pop_q;
`endif

endmodule

// File: tb/tb_bnn_qkv_engine.sv
// Bench for bnn_qkv_engine: vector table plus scoreboard, stall, sequence, clear and reset sequences.
module tb_bnn_qkv_engine;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 16;
  localparam int NUM_BLK = 8;
  localparam int SEQ_LEN = 30;
  localparam int BW      = $clog2(NUM_BLK);
  localparam int ROW     = 3*OUT_W*IN_W;

  typedef struct packed {
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] k;
    logic [OUT_W-1:0] v;
  } qkv_t;

  typedef struct {
    logic [BW-1:0]   blk;
    logic [IN_W-1:0] tok;
    qkv_t            exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [BW-1:0]    block_sel = '0;
  logic             w_en;
  logic [BW-1:0]    w_addr;
  logic [ROW-1:0]   w_data = '0;
  logic [OUT_W-1:0] q_out, k_out, v_out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             done;
  logic             clear = 1'b0;

  logic [ROW-1:0]   rom [NUM_BLK];
  vec_t             tbl [10];
  qkv_t             exp_q [$];
  qkv_t             drv_exp;
  qkv_t             mon_e;
  int               checks = 0;
  int               failures = 0;
  int               hs_cnt = 0;
  int               last_cnt = 0;
  int               cyc = 0;
  int               exp_idx = 0;
  int               hs_cyc [0:1023];

  bnn_qkv_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_BLK(NUM_BLK), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .block_sel(block_sel), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .q_out(q_out), .k_out(k_out), .v_out(v_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done), .clear(clear)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM: row appears the cycle after w_en, held otherwise
  always @(posedge clk) if (w_en) w_data <= rom[w_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic qkv_t model(input int b, input logic [IN_W-1:0] t);
    qkv_t r;
    logic [IN_W-1:0] s;
    int p;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      s = rom[b][i*IN_W +: IN_W];
      p = $countones(~(s ^ t));
      r.q[i] = (2*p >= IN_W);
      s = rom[b][OUT_W*IN_W + i*IN_W +: IN_W];
      p = $countones(~(s ^ t));
      r.k[i] = (2*p >= IN_W);
      s = rom[b][2*OUT_W*IN_W + i*IN_W +: IN_W];
      p = $countones(~(s ^ t));
      r.v[i] = (2*p >= IN_W);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [BW-1:0] b, input logic [IN_W-1:0] t,
                              input logic [15:0] q, input logic [15:0] k, input logic [15:0] v);
    vec_t r;
    r.blk = b;
    r.tok = t;
    r.exp.q = q;
    r.exp.k = k;
    r.exp.v = v;
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("qkv_out", {q_out, k_out, v_out}, mon_e);
        end
        chk("out_last", out_last, exp_idx == SEQ_LEN-1);
        if (out_last) last_cnt++;
        if (hs_cnt < 1024) hs_cyc[hs_cnt] = cyc;
        hs_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_idx <= 0;
    else if (clear) exp_idx <= 0;
    else if (out_valid && out_ready) exp_idx <= (exp_idx == SEQ_LEN-1) ? 0 : exp_idx + 1;
  end

  task automatic send(input logic [BW-1:0] b, input logic [IN_W-1:0] t, input qkv_t e);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    block_sel = b;
    in_data   = t;
    drv_exp   = e;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [BW-1:0] b;
    logic [IN_W-1:0] t;
    b = BW'($urandom_range(0, NUM_BLK-1));
    t = IN_W'($urandom);
    send(b, t, model(int'(b), t));
  endtask

  task automatic wait_hs(input int target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (hs_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("hs_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    logic [3*OUT_W-1:0] snap;

    for (int b = 0; b < NUM_BLK; b++)
      for (int w = 0; w < ROW/32; w++) rom[b][w*32 +: 32] = $urandom;
    rom[0] = '1;
    for (int i = 0; i < OUT_W; i++) begin
      rom[7][i*IN_W +: IN_W]               = 16'h0000;
      rom[7][OUT_W*IN_W + i*IN_W +: IN_W]  = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      rom[7][2*OUT_W*IN_W + i*IN_W +: IN_W] = 16'h00FF;
    end

    tbl[0] = mk(0, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[1] = mk(7, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[2] = mk(0, 16'h007F, 16'h0000, 16'h0000, 16'h0000);
    tbl[3] = mk(7, 16'h007F, 16'hFFFF, 16'hAAAA, 16'hFFFF);
    tbl[4] = mk(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[5] = mk(7, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'h0000);
    tbl[6] = mk(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[7] = mk(7, 16'hFFFE, 16'h0000, 16'h5555, 16'h0000);
    tbl[8] = mk(0, 16'h0F0F, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[9] = mk(7, 16'h0000, 16'hFFFF, 16'hAAAA, 16'hFFFF);

    // Reset state, with a token offered to show w_en stays low
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    block_sel = 3'd5;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w_en", w_en, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_qkv", {q_out, k_out, v_out}, 0);
    chk("rst_done", done, 0);
    chk("rst_out_last", out_last, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(2);

    // Latency: stage 1 one cycle after the handshake, output the cycle after that
    send(tbl[0].blk, tbl[0].tok, tbl[0].exp);
    @(negedge clk);
    chk("lat_cycle1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_out_valid", out_valid, 1);
    chk("lat_cycle2_q", q_out, 16'hFFFF);
    idle(3);

    clear = 1'b1;
    idle(1);
    clear = 1'b0;

    // Full sequence back to back: table vectors then random tokens
    base = hs_cnt;
    last_cnt = 0;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(tbl[i].blk, tbl[i].tok, tbl[i].exp);
        for (int i = 0; i < SEQ_LEN-10; i++) send_rand();
      end
      begin
        for (int n = 0; n < 300; n++) begin
          @(negedge clk);
          if (out_valid && out_last && out_ready) begin
            seen = 1'b1;
            chk("seq_done_before_last", done, 0);
            @(negedge clk);
            chk("seq_done_after_last", done, 1);
            break;
          end
        end
      end
    join
    chk("seq_last_seen", seen, 1);
    idle(4);
    chk("seq_done_sticky", done, 1);
    chk("seq_hs_count", hs_cnt - base, SEQ_LEN);
    chk("seq_consecutive", hs_cyc[base+SEQ_LEN-1] - hs_cyc[base], SEQ_LEN-1);
    chk("seq_last_count", last_cnt, 1);

    // Downstream stall for 5 cycles in mid-stream
    base = hs_cnt;
    fork
      for (int i = 0; i < 10; i++) send_rand();
      begin
        wait_hs(base + 3);
        out_ready = 1'b0;
        @(negedge clk);
        snap = {q_out, k_out, v_out};
        chk("stall_out_valid", out_valid, 1);
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          chk("stall_qkv_stable", {q_out, k_out, v_out}, snap);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_w_en", w_en, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(5);
    chk("stall_hs_count", hs_cnt - base, 10);
    chk("stall_queue_empty", exp_q.size(), 0);
    chk("stall_done_sticky", done, 1);

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_done", done, 0);
    idle(1);

    // Asynchronous reset in the middle of a sequence
    base = hs_cnt;
    fork
      for (int i = 0; i < 20; i++) send_rand();
      begin
        wait_hs(base + 12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_qkv", {q_out, k_out, v_out}, 0);
        chk("arst_done", done, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_w_en", w_en, 0);
        chk("arst_w_addr", w_addr, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    idle(4);

    // Full sequence with clear landing on the last handshake
    seen = 1'b0;
    fork
      for (int i = 0; i < SEQ_LEN; i++) send_rand();
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (out_valid && out_last && out_ready) begin
            seen = 1'b1;
            clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
            break;
          end
        end
      end
    join
    chk("clr_last_seen", seen, 1);
    @(negedge clk);
    chk("clr_last_done", done, 0);
    idle(3);
    chk("clr_last_done_later", done, 0);
    send_rand();
    idle(4);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
